// File: rtl/change_dispenser.sv
// Change-return scheduler: pays an amount out as 20/10/5 coins, largest first,
// one hopper eject handshake at a time, while tracking per-hopper coin inventory.
module change_dispenser #(
    parameter int CNT_W   = 8,
    parameter int INIT_5  = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_20 = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic [7:0]       change_amt,
    input  logic             coin_valid,
    input  logic [2:0]       coin_in,
    input  logic             eject_ack,
    output logic             busy,
    output logic [2:0]       eject,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic [7:0]       remaining,
    output logic [CNT_W-1:0] cnt_5,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_20
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PICK, EJECT, DONE} state_t;

    state_t           state, state_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_d;
    logic [2:0]       eject_d, pick_oh, dep_oh, dec_oh;
    logic [7:0]       remaining_d;
    logic             busy_d, done_d, short_d, fault_d;

    // Simultaneous deposit and payout of the same hopper cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec) return (&cnt) ? cnt : cnt + 1'b1;
        if (dec && !inc) return cnt - 1'b1;
        return cnt;
    endfunction

    function automatic logic [7:0] coin_value(input logic [2:0] oh);
        case (oh)
            3'b001:  return 8'd5;
            3'b010:  return 8'd10;
            3'b100:  return 8'd20;
            default: return 8'd0;
        endcase
    endfunction

    assign dep_oh = (coin_valid && $onehot(coin_in)) ? coin_in : 3'b000;
    assign dec_oh = (state == EJECT && eject_ack) ? eject : 3'b000;

    always_comb begin
        pick_oh = 3'b000;
        if (remaining >= 8'd20 && cnt_20 != '0)      pick_oh = 3'b100;
        else if (remaining >= 8'd10 && cnt_10 != '0) pick_oh = 3'b010;
        else if (remaining >= 8'd5 && cnt_5 != '0)   pick_oh = 3'b001;
    end

    always_comb begin
        state_d     = state;
        eject_d     = eject;
        remaining_d = remaining;
        short_d     = short;
        fault_d     = fault;
        busy_d      = busy;
        done_d      = 1'b0;
        tmo_d       = tmo_cnt;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    remaining_d = change_amt;
                    short_d     = 1'b0;
                    fault_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = PICK;
                end
            end
            PICK: begin
                if (remaining == 8'd0) begin
                    state_d = DONE;
                end else if (pick_oh == 3'b000) begin
                    short_d = 1'b1;
                    state_d = DONE;
                end else begin
                    eject_d = pick_oh;
                    tmo_d   = '0;
                    state_d = EJECT;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    remaining_d = remaining - coin_value(eject);
                    eject_d     = 3'b000;
                    state_d     = PICK;
                end else if (tmo_cnt == TMO_LAST) begin
                    eject_d = 3'b000;
                    short_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_cnt + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            eject     <= 3'b000;
            remaining <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            fault     <= 1'b0;
            cnt_5     <= CNT_W'(INIT_5);
            cnt_10    <= CNT_W'(INIT_10);
            cnt_20    <= CNT_W'(INIT_20);
        end else begin
            state     <= state_d;
            tmo_cnt   <= tmo_d;
            eject     <= eject_d;
            remaining <= remaining_d;
            busy      <= busy_d;
            done      <= done_d;
            short     <= short_d;
            fault     <= fault_d;
            cnt_5     <= cnt_next(cnt_5,  dep_oh[0], dec_oh[0]);
            cnt_10    <= cnt_next(cnt_10, dep_oh[1], dec_oh[1]);
            cnt_20    <= cnt_next(cnt_20, dep_oh[2], dec_oh[2]);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected eject codes and
// end-of-payout results; a monitor pops and compares as the DUT presents them.
module tb_change_dispenser;

    logic       clk, reset_n, req, coin_valid, eject_ack;
    logic [7:0] change_amt;
    logic [2:0] coin_in;
    logic       busy, done, short, fault;
    logic [2:0] eject;
    logic [7:0] remaining;
    logic [7:0] cnt_5, cnt_10, cnt_20;

    int checks   = 0;
    int failures = 0;
    bit auto_ack = 1'b1;

    typedef struct {
        int shrt, flt, rem, c20, c10, c5;
    } res_t;

    int   exp_ej[$];
    res_t exp_res[$];

    change_dispenser #(
        .CNT_W(8), .INIT_5(8), .INIT_10(8), .INIT_20(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .change_amt(change_amt),
        .coin_valid(coin_valid), .coin_in(coin_in), .eject_ack(eject_ack),
        .busy(busy), .eject(eject), .done(done), .short(short), .fault(fault),
        .remaining(remaining), .cnt_5(cnt_5), .cnt_10(cnt_10), .cnt_20(cnt_20)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ej(input int code, input int times);
        for (int i = 0; i < times; i++) exp_ej.push_back(code);
    endtask

    task automatic push_res(input int s, input int f, input int r,
                            input int c20, input int c10, input int c5);
        res_t t;
        t.shrt = s; t.flt = f; t.rem = r; t.c20 = c20; t.c10 = c10; t.c5 = c5;
        exp_res.push_back(t);
    endtask

    // Hopper model: acknowledge on the first edge of every eject when enabled.
    initial begin
        eject_ack = 1'b0;
        forever begin
            @(negedge clk);
            eject_ack = auto_ack && (eject != 3'b000);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [2:0] prev_ej;
        int         e;
        res_t       r;
        prev_ej = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (eject != 3'b000 && prev_ej == 3'b000) begin
                if (exp_ej.size() == 0) check("unexpected_eject", int'(eject), 0);
                else begin
                    e = exp_ej.pop_front();
                    check("eject_code", int'(eject), e);
                end
            end
            prev_ej = eject;
            if (done) begin
                if (exp_res.size() == 0) check("unexpected_done", int'(done), 0);
                else begin
                    r = exp_res.pop_front();
                    check("short", int'(short), r.shrt);
                    check("fault", int'(fault), r.flt);
                    check("remaining", int'(remaining), r.rem);
                    check("cnt_20", int'(cnt_20), r.c20);
                    check("cnt_10", int'(cnt_10), r.c10);
                    check("cnt_5", int'(cnt_5), r.c5);
                end
            end
        end
    end

    // Issue one request; n = edges from acceptance to done, ejc = cycles with eject active.
    task automatic run_req(input int amt, input bit poke, output int n, output int ejc);
        @(negedge clk);
        req = 1'b1;
        change_amt = 8'(amt);
        @(posedge clk);
        #1;
        req = 1'b0;
        n = 0;
        ejc = 0;
        while (n < 400) begin
            if (poke && n == 3) begin
                req = 1'b1;
                change_amt = 8'd5;
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
            n++;
            #1;
            if (eject != 3'b000) ejc++;
            if (done) break;
        end
        req = 1'b0;
        if (!done) check("done_wait_expired", int'(done), 1);
    endtask

    task automatic deposit(input logic [2:0] c);
        @(negedge clk);
        coin_valid = 1'b1;
        coin_in = c;
        @(negedge clk);
        coin_valid = 1'b0;
        coin_in = 3'b000;
    endtask

    task automatic busy_falls;
        @(posedge clk);
        #1;
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int n, ejc;
        reset_n = 1'b0;
        req = 1'b0;
        change_amt = 8'd0;
        coin_valid = 1'b0;
        coin_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_eject", int'(eject), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_cnt_20", int'(cnt_20), 8);
        check("rst_cnt_10", int'(cnt_10), 8);
        check("rst_cnt_5", int'(cnt_5), 8);
        @(negedge clk);
        reset_n = 1'b1;

        // 35 = 20 + 10 + 5
        push_ej(4, 1); push_ej(2, 1); push_ej(1, 1);
        push_res(0, 0, 0, 7, 7, 7);
        run_req(35, 1'b0, n, ejc);
        check("done_latency_35", n, 8);
        busy_falls();

        // zero amount goes straight to done
        push_res(0, 0, 0, 7, 7, 7);
        run_req(0, 1'b0, n, ejc);
        check("done_latency_0", n, 2);
        busy_falls();

        // 140 drains the 20 hopper; a req while busy must be ignored
        push_ej(4, 7);
        push_res(0, 0, 0, 0, 7, 7);
        run_req(140, 1'b1, n, ejc);
        busy_falls();

        // 40 with no 20s left: four 10s
        push_ej(2, 4);
        push_res(0, 0, 0, 0, 3, 7);
        run_req(40, 1'b0, n, ejc);
        busy_falls();

        // deposit a 10 on the edge that acks a 10 eject
        push_ej(2, 1);
        push_res(0, 0, 0, 0, 3, 7);
        fork
            run_req(10, 1'b0, n, ejc);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (eject != 3'b010 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                coin_valid = 1'b1;
                coin_in = 3'b010;
                @(posedge clk);
                #1;
                check("cnt10_dep_on_ack", int'(cnt_10), 3);
                @(negedge clk);
                coin_valid = 1'b0;
                coin_in = 3'b000;
            end
        join
        busy_falls();

        // non-one-hot deposit is ignored
        deposit(3'b011);
        #1;
        check("bad_coin_cnt_20", int'(cnt_20), 0);
        check("bad_coin_cnt_10", int'(cnt_10), 3);
        check("bad_coin_cnt_5", int'(cnt_5), 7);

        // 47 leaves a residue of 2
        push_ej(2, 3); push_ej(1, 3);
        push_res(1, 0, 2, 0, 0, 4);
        run_req(47, 1'b0, n, ejc);
        busy_falls();

        // 20 paid entirely in fives
        push_ej(1, 4);
        push_res(0, 0, 0, 0, 0, 0);
        run_req(20, 1'b0, n, ejc);
        busy_falls();

        // one 10 in stock, no fives: 15 pays 10 and falls short by 5
        deposit(3'b010);
        #1;
        check("dep_cnt_10", int'(cnt_10), 1);
        push_ej(2, 1);
        push_res(1, 0, 5, 0, 0, 0);
        run_req(15, 1'b0, n, ejc);
        busy_falls();

        // hopper never acknowledges
        deposit(3'b100);
        #1;
        check("dep_cnt_20", int'(cnt_20), 1);
        auto_ack = 1'b0;
        push_ej(4, 1);
        push_res(1, 1, 20, 1, 0, 0);
        run_req(20, 1'b0, n, ejc);
        check("timeout_eject_cycles", ejc, 16);
        busy_falls();
        check("fault_held", int'(fault), 1);

        // reset in the middle of an eject
        push_ej(4, 1);
        @(negedge clk);
        req = 1'b1;
        change_amt = 8'd20;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("eject_before_reset", int'(eject), 4);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_eject", int'(eject), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_cnt_20", int'(cnt_20), 8);
        check("mid_rst_cnt_10", int'(cnt_10), 8);
        check("mid_rst_cnt_5", int'(cnt_5), 8);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("ej_queue_left", exp_ej.size(), 0);
        check("res_queue_left", exp_res.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
